wb_ram_arbiter: RTL and testbench
=================================

// Module: wb_ram_arbiter
// PURPOSE
//  Round-robin Wishbone arbiter sharing the single SRAM slave (wb_ram0) between the CPU, DSP and DAQ bus masters.
//  Grants one master at a time and passes its cycle through to the RAM, including classic and incrementing bursts.
//  Routes ack/err/rty back only to the granted master.
//  A per-transfer watchdog aborts any stalled access and returns err, so a hung slave cannot lock the bus.
// PARAMETERS
//  NUM_M    3   number of masters; index 0=cpu, 1=dsp, 2=daq
//  AW       32  address width
//  DW       32  data width; SEL width is DW/8
//  TIMEOUT  64  max cycles stb may wait for ack/err/rty; 0 disables the watchdog
// PORTS
//  wb_clk   in   1          system clock; all logic on the rising edge
//  wb_rst   in   1          synchronous, active-high reset
//  m_adr_i  in   NUM_M*AW   packed master addresses; master i occupies [i*AW +: AW]
//  m_dat_i  in   NUM_M*DW   packed master write data
//  m_sel_i  in   NUM_M*DW/8 packed byte selects
//  m_we_i   in   NUM_M      write enables
//  m_cyc_i  in   NUM_M      cycle requests
//  m_stb_i  in   NUM_M      strobes
//  m_cti_i  in   NUM_M*3    cycle type identifiers
//  m_bte_i  in   NUM_M*2    burst type extensions
//  m_dat_o  out  DW         read data, broadcast to all masters
//  m_ack_o  out  NUM_M      ack, asserted only for the granted master
//  m_err_o  out  NUM_M      err: slave err or watchdog abort
//  m_rty_o  out  NUM_M      rty, asserted only for the granted master
//  s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cti_o/s_bte_o  out  AW/DW/DW/8/1/3/2  muxed from the granted master
//  s_cyc_o  out  1          slave cycle
//  s_stb_o  out  1          slave strobe
//  s_dat_i  in   DW         slave read data
//  s_ack_i/s_err_i/s_rty_i  in  1  slave responses
//  grant_o  out  NUM_M      one-hot current grant; zero when idle
// BEHAVIOUR
//  Reset values
//   - All outputs are 0.
//   - FSM is in IDLE.
//   - last_grant = NUM_M-1, so master 0 wins the first arbitration.
//   - Watchdog counter is 0.
//  FSM: IDLE, BUSY, ABORT
//  IDLE
//   - If any m_cyc_i is set, register a grant to the first requester after last_grant, scanning cyclically.
//   - Then enter BUSY.
//   - Arbitration latency is one cycle: cyc seen in cycle N, slave sees cyc in N+1.
//  BUSY
//   - s_* outputs are combinational from the granted master.
//   - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g].
//   - s_ack_i, s_err_i and s_rty_i go combinationally to bit g of m_ack_o/m_err_o/m_rty_o only; the other bits stay 0.
//   - m_dat_o = s_dat_i at all times.
//  Grant hold
//   - The grant is held while m_cyc_i[g]=1, regardless of cti.
//   - Bursts (cti 001/010 ending in 111) are never split.
//   - Other requests wait.
//  Release
//   - When m_cyc_i[g]=0: last_grant <= g, grant_o <= 0, go to IDLE.
//   - There is one dead cycle between back-to-back owners.
//  Watchdog
//   - The counter increments each cycle with s_stb_o=1 and no ack/err/rty.
//   - It clears on any response or when stb is low.
//   - When the count reaches TIMEOUT, in that cycle:
//     - m_err_o[g]=1 for exactly one cycle;
//     - s_cyc_o and s_stb_o are forced to 0 from that cycle on;
//     - the FSM goes to ABORT.
//  ABORT
//   - Slave outputs are held at 0 and no responses are forwarded.
//   - Wait for m_cyc_i[g]=0, then set last_grant <= g and go to IDLE.
//  Simultaneous events
//   - A slave response in the same cycle as the watchdog limit wins: it is forwarded and there is no abort.
//   - A newly requesting master never preempts the granted master.
//   - A master that dropped cyc is skipped at the next arbitration even if it re-raises cyc in the same cycle it is skipped.
//  Reset mid-operation
//   - Takes effect at the next edge: s_cyc_o and s_stb_o are 0 the cycle after, and all state returns to reset values.
// TESTING
//  1. Master 0 single write adr=0x10 dat=0xCAFEF00D, slave acks in 1 cycle -> s_cyc_o rises 1 cycle after m_cyc_i[0]; m_ack_o=3'b001; readback returns 0xCAFEF00D.
//  2. All three masters raise cyc in the same cycle after reset, each does one access -> grant_o sequence 001, 010, 100, with one idle cycle between grants.
//  3. Master 1 runs a 4-beat incrementing burst (cti 010,010,010,111); master 0 requests at beat 2 -> master 0 is not granted until master 1 drops cyc; all 4 acks go to m_ack_o[1] only.
//  4. TIMEOUT=16, slave never acks master 2 -> m_err_o[2] pulses for 1 cycle exactly 16 cycles after s_stb_o rose; s_cyc_o=0 thereafter; arbiter returns to IDLE after master 2 drops cyc.
//  5. Slave acks in the same cycle the count reaches TIMEOUT -> ack is forwarded, no err, grant kept.
//  6. wb_rst asserted mid-burst -> next cycle all outputs are 0; after release the first grant goes to master 0.

Source files
------------

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone arbiter sharing one SRAM slave between NUM_M masters,
// with a per-transfer watchdog that aborts stalled accesses with err.
module wb_ram_arbiter #(
    parameter int NUM_M   = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic [NUM_M*AW-1:0]   m_adr_i,
    input  logic [NUM_M*DW-1:0]   m_dat_i,
    input  logic [NUM_M*DW/8-1:0] m_sel_i,
    input  logic [NUM_M-1:0]      m_we_i,
    input  logic [NUM_M-1:0]      m_cyc_i,
    input  logic [NUM_M-1:0]      m_stb_i,
    input  logic [NUM_M*3-1:0]    m_cti_i,
    input  logic [NUM_M*2-1:0]    m_bte_i,
    output logic [DW-1:0]         m_dat_o,
    output logic [NUM_M-1:0]      m_ack_o,
    output logic [NUM_M-1:0]      m_err_o,
    output logic [NUM_M-1:0]      m_rty_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [DW/8-1:0]       s_sel_o,
    output logic                  s_we_o,
    output logic [2:0]            s_cti_o,
    output logic [1:0]            s_bte_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    input  logic [DW-1:0]         s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    output logic [NUM_M-1:0]      grant_o
);
    localparam int SW = DW / 8;
    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_ABORT = 2'b10
    } state_t;

    state_t           state_r, state_s;
    logic [NUM_M-1:0] grant_r, grant_s;
    logic [IW-1:0]    gidx_r, gidx_s;
    logic [IW-1:0]    last_r, last_s;
    logic             skip_r, skip_s;
    logic [WW-1:0]    wdog_r, wdog_s;
    logic [NUM_M-1:0] req_s;
    logic             pick_vld_s;
    logic [IW-1:0]    pick_idx_s;
    logic             hit_s;
    int               cand_s;
    logic             cyc_g_s, stb_g_s, resp_s, timeout_s;

    function automatic logic [NUM_M-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_M-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign cyc_g_s = m_cyc_i[gidx_r];
    assign stb_g_s = m_stb_i[gidx_r];
    assign resp_s  = s_ack_i | s_err_i | s_rty_i;
    assign grant_o = grant_r;

    // The master that just released is masked for one arbitration round
    always_comb begin
        req_s = m_cyc_i;
        if (skip_r) req_s = m_cyc_i & ~onehot(last_r);
        else        req_s = m_cyc_i;
    end

    // Cyclic scan starting just after the last owner
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = '0;
        hit_s      = 1'b0;
        cand_s     = 0;
        for (int off = 1; off <= NUM_M; off++) begin
            cand_s     = int'(last_r) + off;
            cand_s     = (cand_s >= NUM_M) ? cand_s - NUM_M : cand_s;
            hit_s      = !pick_vld_s && req_s[cand_s];
            pick_idx_s = hit_s ? IW'(cand_s) : pick_idx_s;
            pick_vld_s = pick_vld_s | hit_s;
        end
    end

    // Watchdog limit; a slave response in the same cycle takes priority
    always_comb begin
        timeout_s = 1'b0;
        if (TIMEOUT > 0)
            timeout_s = (state_r == ST_BUSY) && cyc_g_s && stb_g_s && !resp_s &&
                        (wdog_r == WW'(TIMEOUT));
        else
            timeout_s = 1'b0;
    end

    // Slave-side mux and response routing to the granted master
    always_comb begin
        m_dat_o = s_dat_i;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cti_o = 3'b000;
        s_bte_o = 2'b00;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        case (state_r)
            ST_BUSY: begin
                s_adr_o = m_adr_i[gidx_r*AW +: AW];
                s_dat_o = m_dat_i[gidx_r*DW +: DW];
                s_sel_o = m_sel_i[gidx_r*SW +: SW];
                s_we_o  = m_we_i[gidx_r];
                s_cti_o = m_cti_i[gidx_r*3 +: 3];
                s_bte_o = m_bte_i[gidx_r*2 +: 2];
                s_cyc_o = cyc_g_s & ~timeout_s;
                s_stb_o = stb_g_s & ~timeout_s;
                m_ack_o = s_ack_i ? grant_r : '0;
                m_rty_o = s_rty_i ? grant_r : '0;
                m_err_o = (s_err_i | timeout_s) ? grant_r : '0;
            end
            ST_IDLE:  begin end
            ST_ABORT: begin end
            default:  begin end
        endcase
    end

    // Next-state: arbitration, grant hold/release and watchdog count
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        gidx_s  = gidx_r;
        last_s  = last_r;
        skip_s  = skip_r;
        wdog_s  = '0;
        case (state_r)
            ST_IDLE: begin
                skip_s = 1'b0;
                if (pick_vld_s) begin
                    grant_s = onehot(pick_idx_s);
                    gidx_s  = pick_idx_s;
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!cyc_g_s) begin
                    last_s  = gidx_r;
                    grant_s = '0;
                    skip_s  = 1'b1;
                    state_s = ST_IDLE;
                end else if (timeout_s) begin
                    state_s = ST_ABORT;
                end else if (stb_g_s && !resp_s) begin
                    wdog_s = wdog_r + WW'(1);
                end else begin
                    wdog_s = '0;
                end
            end
            ST_ABORT: begin
                if (!cyc_g_s) begin
                    last_s  = gidx_r;
                    grant_s = '0;
                    skip_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ABORT;
                end
            end
            default: begin
                grant_s = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            gidx_r  <= '0;
            last_r  <= IW'(NUM_M - 1);
            skip_r  <= 1'b0;
            wdog_r  <= '0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            gidx_r  <= gidx_s;
            last_r  <= last_s;
            skip_r  <= skip_s;
            wdog_r  <= wdog_s;
        end
    end
endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Scoreboard bench for wb_ram_arbiter: directed master traffic against a
// small SRAM slave model with programmable ack latency.
module tb_wb_ram_arbiter;
    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic wb_clk = 1'b0;
    logic wb_rst;
    always #5 wb_clk = ~wb_clk;

    logic [31:0] adr_v [NM];
    logic [31:0] dat_v [NM];
    logic [3:0]  sel_v [NM];
    logic [2:0]  cti_v [NM];
    logic        we_v  [NM];
    logic        cyc_v [NM];
    logic        stb_v [NM];

    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM*4-1:0]  m_sel_i;
    logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i;
    logic [NM*3-1:0]  m_cti_i;
    logic [NM*2-1:0]  m_bte_i;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o, s_dat_i;
    logic [3:0]       s_sel_o;
    logic             s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]       s_cti_o;
    logic [1:0]       s_bte_o;
    logic             s_ack_i;
    logic             s_err_i = 1'b0;
    logic             s_rty_i = 1'b0;

    assign m_adr_i = {adr_v[2], adr_v[1], adr_v[0]};
    assign m_dat_i = {dat_v[2], dat_v[1], dat_v[0]};
    assign m_sel_i = {sel_v[2], sel_v[1], sel_v[0]};
    assign m_cti_i = {cti_v[2], cti_v[1], cti_v[0]};
    assign m_we_i  = {we_v[2], we_v[1], we_v[0]};
    assign m_cyc_i = {cyc_v[2], cyc_v[1], cyc_v[0]};
    assign m_stb_i = {stb_v[2], stb_v[1], stb_v[0]};
    assign m_bte_i = '0;

    wb_ram_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    // SRAM slave model: ack after sl_delay cycles of continuous strobe
    logic [31:0] mem [256];
    logic        sl_en;
    int          sl_delay;
    int          sl_cnt = 0;
    assign s_ack_i = sl_en && (sl_cnt == sl_delay);
    assign s_dat_i = mem[s_adr_o[9:2]];
    always @(posedge wb_clk) begin
        if (s_ack_i && s_stb_o && s_we_o) mem[s_adr_o[9:2]] <= s_dat_o;
        sl_cnt <= (s_stb_o && !s_ack_i) ? sl_cnt + 1 : 0;
    end

    int cyc_n = 0;
    always @(posedge wb_clk) cyc_n <= cyc_n + 1;

    int n_cmp = 0;
    int n_fail = 0;
    int stb_rise_cyc = 0;
    int last_seen_cyc = 0;
    int ack_seen [NM] = '{0, 0, 0};

    typedef struct packed {
        logic        is_err;
        logic        chk;
        logic [31:0] dat;
    } resp_t;
    typedef struct packed {
        logic [2:0] g;
        logic [7:0] gap;
    } gr_t;

    resp_t q0[$], q1[$], q2[$];
    gr_t   gq[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic push_resp(input int m, input resp_t r);
        case (m)
            0: q0.push_back(r);
            1: q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endtask

    function automatic int q_size(input int m);
        case (m)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic resp_t pop_resp(input int m);
        case (m)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: responses and new grants are checked against the queues
    initial begin
        logic [2:0] prev_g;
        logic       prev_stb;
        int         zero_run;
        resp_t      r;
        gr_t        g;
        prev_g = '0; prev_stb = 1'b0; zero_run = 0;
        forever begin
            @(negedge wb_clk);
            if (!wb_rst) begin
                if (s_stb_o && !prev_stb) stb_rise_cyc = cyc_n;
                for (int m = 0; m < NM; m++) begin
                    if (m_ack_o[m] || m_err_o[m] || m_rty_o[m]) begin
                        if (m_ack_o[m]) ack_seen[m]++;
                        if (q_size(m) == 0) begin
                            n_cmp++; n_fail++;
                            $display("FAIL unexpected_resp_m%0d: got ack=%b err=%b rty=%b, required none",
                                     m, m_ack_o, m_err_o, m_rty_o);
                        end else begin
                            r = pop_resp(m);
                            check($sformatf("resp_err_m%0d", m), 32'(m_err_o[m]), 32'(r.is_err));
                            check($sformatf("resp_onehot_m%0d", m), 32'(m_ack_o | m_err_o | m_rty_o), 32'(1) << m);
                            if (r.chk && !r.is_err) check($sformatf("rd_dat_m%0d", m), m_dat_o, r.dat);
                        end
                    end
                end
                if (grant_o != 3'b000 && prev_g == 3'b000) begin
                    if (gq.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_grant: got %b, required none", grant_o);
                    end else begin
                        g = gq.pop_front();
                        check("grant", 32'(grant_o), 32'(g.g));
                        if (g.gap != 8'hFF) check("grant_gap", 32'(zero_run), 32'(g.gap));
                    end
                end
                zero_run = (grant_o == 3'b000) ? zero_run + 1 : 0;
            end else begin
                zero_run = 0;
            end
            prev_g   = grant_o;
            prev_stb = s_stb_o;
        end
    end

    task automatic wait_resp(input int m);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge wb_clk);
            seen = m_ack_o[m] | m_err_o[m] | m_rty_o[m];
        end
        if (seen) begin
            last_seen_cyc = cyc_n;
        end else begin
            n_cmp++; n_fail++;
            $display("FAIL resp_timeout_m%0d: got no response, required one within 100 cycles", m);
        end
    endtask

    task automatic do_cycle(input int m, input int nb, input logic [31:0] adr0, input logic we,
                            input logic [31:0] dat0, input logic chk, input logic [31:0] exp0,
                            input logic keep);
        resp_t r;
        for (int b = 0; b < nb; b++) begin
            adr_v[m] = adr0 + 32'(4 * b);
            dat_v[m] = dat0 + 32'(b);
            we_v[m]  = we;
            sel_v[m] = 4'hF;
            cti_v[m] = (nb == 1) ? 3'b000 : ((b == nb - 1) ? 3'b111 : 3'b010);
            cyc_v[m] = 1'b1;
            stb_v[m] = 1'b1;
            r.is_err = 1'b0; r.chk = chk; r.dat = exp0 + 32'(b);
            push_resp(m, r);
            wait_resp(m);
            @(posedge wb_clk); #1;
        end
        stb_v[m] = 1'b0; cti_v[m] = 3'b000; we_v[m] = 1'b0;
        if (!keep) begin
            cyc_v[m] = 1'b0;
            @(posedge wb_clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        resp_t r;
        for (int i = 0; i < NM; i++) begin
            adr_v[i] = '0; dat_v[i] = '0; sel_v[i] = '0; cti_v[i] = '0;
            we_v[i] = 1'b0; cyc_v[i] = 1'b0; stb_v[i] = 1'b0;
        end
        for (int i = 0; i < 256; i++) mem[i] = '0;
        sl_en = 1'b1; sl_delay = 1; wb_rst = 1'b1;

        // Reset state
        repeat (3) @(posedge wb_clk);
        @(negedge wb_clk);
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        check("rst_s_stb", 32'(s_stb_o), 32'h0);
        check("rst_ack", 32'(m_ack_o), 32'h0);
        check("rst_err", 32'(m_err_o), 32'h0);
        @(posedge wb_clk); #1; wb_rst = 1'b0;

        // 1: single write then readback by master 0, one-cycle arbitration latency
        gq.push_back('{g: 3'b001, gap: 8'hFF});
        fork
            do_cycle(0, 1, 32'h10, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
            begin
                @(negedge wb_clk); check("t1_cyc_same_cycle", 32'(s_cyc_o), 32'h0);
                @(negedge wb_clk); check("t1_cyc_next_cycle", 32'(s_cyc_o), 32'h1);
            end
        join
        gq.push_back('{g: 3'b001, gap: 8'hFF});
        do_cycle(0, 1, 32'h10, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);

        // 2: all three request together after reset
        wb_rst = 1'b1; @(posedge wb_clk); #1; wb_rst = 1'b0;
        gq.push_back('{g: 3'b001, gap: 8'hFF});
        gq.push_back('{g: 3'b010, gap: 8'd1});
        gq.push_back('{g: 3'b100, gap: 8'd1});
        fork
            do_cycle(0, 1, 32'h100, 1'b1, 32'h11111111, 1'b0, 32'h0, 1'b0);
            do_cycle(1, 1, 32'h104, 1'b1, 32'h22222222, 1'b0, 32'h0, 1'b0);
            do_cycle(2, 1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h11111111, 1'b0);
        join

        // 3: master 1 burst is not split by master 0 requesting mid-burst
        gq.push_back('{g: 3'b010, gap: 8'hFF});
        gq.push_back('{g: 3'b001, gap: 8'd1});
        base = ack_seen[1];
        fork
            do_cycle(1, 4, 32'h40, 1'b1, 32'hA0000000, 1'b0, 32'h0, 1'b0);
            begin
                for (int i = 0; i < 100 && ack_seen[1] == base; i++) @(negedge wb_clk);
                @(posedge wb_clk); #1;
                do_cycle(0, 1, 32'h44, 1'b0, 32'h0, 1'b1, 32'hA0000001, 1'b0);
            end
        join

        // 4: watchdog abort on master 2
        sl_en = 1'b0;
        gq.push_back('{g: 3'b100, gap: 8'hFF});
        r = '{is_err: 1'b1, chk: 1'b0, dat: 32'h0};
        push_resp(2, r);
        adr_v[2] = 32'h0; we_v[2] = 1'b0; sel_v[2] = 4'hF; cti_v[2] = 3'b000;
        cyc_v[2] = 1'b1; stb_v[2] = 1'b1;
        wait_resp(2);
        check("t4_err_latency", 32'(last_seen_cyc - stb_rise_cyc), 32'd16);
        @(posedge wb_clk); #1; stb_v[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk); check("t4_abort_s_cyc", 32'(s_cyc_o), 32'h0);
        end
        @(posedge wb_clk); #1; cyc_v[2] = 1'b0;
        @(negedge wb_clk);
        @(negedge wb_clk); check("t4_idle_grant", 32'(grant_o), 32'h0);
        sl_en = 1'b1;
        @(posedge wb_clk); #1;

        // 5: ack arriving exactly at the watchdog limit wins
        sl_delay = 16;
        gq.push_back('{g: 3'b010, gap: 8'hFF});
        do_cycle(1, 1, 32'h80, 1'b1, 32'h5555AAAA, 1'b0, 32'h0, 1'b1);
        check("t5_ack_latency", 32'(last_seen_cyc - stb_rise_cyc), 32'd16);
        @(negedge wb_clk); check("t5_grant_kept", 32'(grant_o), 32'h2);
        @(posedge wb_clk); #1; cyc_v[1] = 1'b0;
        @(posedge wb_clk); #1;
        sl_delay = 1;

        // 6: reset in the middle of a master 0 burst
        gq.push_back('{g: 3'b001, gap: 8'hFF});
        we_v[0] = 1'b1; sel_v[0] = 4'hF; cti_v[0] = 3'b010;
        adr_v[0] = 32'hC0; dat_v[0] = 32'hB0000000; cyc_v[0] = 1'b1; stb_v[0] = 1'b1;
        r = '{is_err: 1'b0, chk: 1'b0, dat: 32'h0};
        push_resp(0, r);
        wait_resp(0);
        @(posedge wb_clk); #1;
        adr_v[0] = 32'hC4; dat_v[0] = 32'hB0000001;
        push_resp(0, r);
        wait_resp(0);
        @(posedge wb_clk); #1;
        adr_v[0] = 32'hC8; dat_v[0] = 32'hB0000002; wb_rst = 1'b1;
        @(posedge wb_clk); #1;
        wb_rst = 1'b0; cyc_v[0] = 1'b0; stb_v[0] = 1'b0; cti_v[0] = 3'b000; we_v[0] = 1'b0;
        @(negedge wb_clk);
        check("t6_s_cyc", 32'(s_cyc_o), 32'h0);
        check("t6_s_stb", 32'(s_stb_o), 32'h0);
        check("t6_grant", 32'(grant_o), 32'h0);
        check("t6_s_adr", s_adr_o, 32'h0);
        check("t6_ack", 32'(m_ack_o), 32'h0);
        check("t6_err", 32'(m_err_o), 32'h0);
        @(posedge wb_clk); #1;
        gq.push_back('{g: 3'b001, gap: 8'hFF});
        gq.push_back('{g: 3'b010, gap: 8'd1});
        fork
            do_cycle(1, 1, 32'hC4, 1'b0, 32'h0, 1'b1, 32'hB0000001, 1'b0);
            do_cycle(0, 1, 32'hC0, 1'b0, 32'h0, 1'b1, 32'hB0000000, 1'b0);
        join

        repeat (3) @(posedge wb_clk);
        check("queues_drained", 32'(q0.size() + q1.size() + q2.size() + gq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
